lutram_access_arbiter: RTL and testbench
========================================

LUTRAM_ACCESS_ARBITER -- requirements
Module: lutram_access_arbiter

Interface
REQ-001 SHALL have parameter SINGLE_ELEMENT_SIZE_IN_BITS, default 64: data width of one entry.
REQ-002 SHALL have parameter NUMBER_SETS, default 64: number of entries (any value >= 2).
REQ-003 SHALL have parameter SET_PTR_WIDTH_IN_BITS, default $clog2(NUMBER_SETS): address width.
REQ-004 SHALL have port clk_in, input, 1: the single clock.
REQ-005 SHALL have port reset_n_in, input, 1: reset, asynchronous assert and active-low.
REQ-006 SHALL have ports reqN_valid_in (N=0,1), input, 1: requester N presents a request.
REQ-007 SHALL have ports reqN_ready_out, output, 1: request accepted this cycle when valid & ready.
REQ-008 SHALL have ports reqN_write_en_in, input, 1: 1 = write, 0 = read.
REQ-009 SHALL have ports reqN_addr_in, input, SET_PTR_WIDTH_IN_BITS: entry index.
REQ-010 SHALL have ports reqN_data_in, input, SINGLE_ELEMENT_SIZE_IN_BITS: write data.
REQ-011 SHALL have ports respN_valid_out, output, 1: read data valid, one-cycle pulse.
REQ-012 SHALL have ports respN_data_out, output, SINGLE_ELEMENT_SIZE_IN_BITS: registered read data.
REQ-013 SHALL have ports lutram_access_en_out, lutram_write_en_out (output, 1), lutram_addr_out (output, SET_PTR_WIDTH_IN_BITS) and lutram_write_data_out (output, SINGLE_ELEMENT_SIZE_IN_BITS): drive the single-port LUTRAM.
REQ-014 SHALL have port lutram_read_data_in, input, SINGLE_ELEMENT_SIZE_IN_BITS: combinational read data from the LUTRAM.
REQ-015 SHALL have port init_done_out, output, 1: high once the storage is initialised and serving.

Function
REQ-016 SHALL implement the FSM states INIT_SWEEP and SERVE, with INIT_SWEEP as the reset state.
REQ-017 INIT_SWEEP SHALL write zero to addresses 0..NUMBER_SETS-1, one per cycle, using a sweep counter; both ready outputs are low.
REQ-018 After the write to NUMBER_SETS-1, SHALL enter SERVE and raise init_done_out in the next cycle; the counter SHALL NOT wrap.
REQ-019 In SERVE, at most one request SHALL be granted per cycle: readyN is high only for the granted valid requester, and readyN SHALL NOT depend on readyM.
REQ-020 Arbitration SHALL be round-robin: with both valid, the requester not granted last wins. A single valid requester wins immediately.
REQ-021 In the grant cycle, the lutram_* outputs SHALL carry the granted request combinationally (access_en=1); otherwise access_en=0 and write_en=0.
REQ-022 A granted read SHALL register lutram_read_data_in into respN_data_out, and respN_valid_out SHALL pulse exactly one cycle later (latency 1).
REQ-023 A granted write SHALL produce no response.
REQ-024 respN_data_out SHALL hold its value until the next read response to N.
REQ-025 Same-address write then read SHALL be serialised by arbitration; a read granted in the cycle after a write returns the new data.
REQ-026 A request held valid without ready SHALL keep its fields stable, and the arbiter SHALL grant it within 2 cycles (no starvation).

Reset
REQ-027 When reset_n_in is low, SHALL force: state=INIT_SWEEP, sweep counter=0, round-robin pointer=req0 preferred, all ready/resp_valid/lutram enables=0, resp data=0, init_done_out=0.
REQ-028 Reset asserted mid-sweep or mid-serve SHALL abort the operation and restart the sweep from address 0; a pending response SHALL be dropped.

Configuration
REQ-029 SHALL use macro LUTRAM_ACCESS_ARBITER_INIT_SWEEP_EN; when defined, the behaviour of REQ-017/018 applies.
REQ-030 When LUTRAM_ACCESS_ARBITER_INIT_SWEEP_EN is undefined, SHALL omit the sweep counter and INIT_SWEEP; the reset state is SERVE, init_done_out=1 from the first clock after reset release, and LUTRAM contents are undefined until written.

Structure
REQ-031 A shared package SHALL hold the FSM state encoding and the requester-index constants (REQ0=0, REQ1=1).
REQ-032 Round-robin grant logic SHALL be one sub-module, rr_arbiter_2 (2 requests, 1 last-grant pointer, one-hot grant).

Verification
REQ-033 Macro on, NUMBER_SETS=64, release reset: 64 cycles of zero writes to addr 0..63 with ready low; init_done_out=1 at cycle 65; read addr 5 -> resp data 0.
REQ-034 req0 writes 0xDEAD to addr 3, then req1 reads addr 3 in the next cycle -> resp1_valid_out one cycle after its grant with data 0xDEAD; resp0_valid_out stays 0.
REQ-035 Both requesters continuously valid with reads -> grants alternate 0,1,0,1 starting with req0 after reset.
REQ-036 Assert reset_n_in low when the sweep counter is 20 -> all outputs reset; after release, the sweep restarts at address 0 and init_done_out rises 65 cycles later.
REQ-037 Macro off: release reset -> init_done_out=1 and req0 read granted in the first cycle; read-after-write of 0x1 to addr 63 returns 0x1.

Source files
------------

// File: rtl/lutram_access_arbiter_pkg.sv
// Shared types for the LUTRAM access arbiter.
// Holds the FSM encoding and requester indices.
package lutram_access_arbiter_pkg;

  typedef enum logic {
    INIT_SWEEP = 1'b0,
    SERVE      = 1'b1
  } state_e;

  localparam int unsigned NUM_REQ = 2;
  localparam int unsigned REQ0    = 0;
  localparam int unsigned REQ1    = 1;

endpackage

// File: rtl/lutram_access_arbiter_if.sv
// One requester's valid/ready request channel plus its read response.
// master = requester side, slave = arbiter side.
interface lutram_access_arbiter_if #(
  parameter int unsigned SINGLE_ELEMENT_SIZE_IN_BITS = 64,
  parameter int unsigned SET_PTR_WIDTH_IN_BITS       = 6
) ();

  logic                                   valid;
  logic                                   ready;
  logic                                   write_en;
  logic [SET_PTR_WIDTH_IN_BITS-1:0]       addr;
  logic [SINGLE_ELEMENT_SIZE_IN_BITS-1:0] data;
  logic                                   resp_valid;
  logic [SINGLE_ELEMENT_SIZE_IN_BITS-1:0] resp_data;

  modport master (
    output valid, write_en, addr, data,
    input  ready, resp_valid, resp_data
  );

  modport slave (
    input  valid, write_en, addr, data,
    output ready, resp_valid, resp_data
  );

endinterface

// File: rtl/lutram_access_arbiter_rr_arbiter_2.sv
// Two-way round-robin arbiter with a one-hot grant.
// After reset requester 0 is preferred.
module rr_arbiter_2
  import lutram_access_arbiter_pkg::*;
(
  input  logic               clk_in,
  input  logic               reset_n_in,
  input  logic               en_in,
  input  logic [NUM_REQ-1:0] req_in,
  output logic [NUM_REQ-1:0] grant_out
);

  // 1 means requester 1 won last, so requester 0 goes first
  logic last_q;

  always_comb begin
    grant_out = '0;
    if (en_in) begin
      case (req_in)
        2'b01:   grant_out[REQ0] = 1'b1;
        2'b10:   grant_out[REQ1] = 1'b1;
        2'b11: begin
          if (last_q) grant_out[REQ0] = 1'b1;
          else        grant_out[REQ1] = 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk_in or negedge reset_n_in) begin
    if (!reset_n_in) begin
      last_q <= 1'b1;
    end else if (|grant_out) begin
      last_q <= grant_out[REQ1];
    end
  end

endmodule

// File: rtl/lutram_access_arbiter.sv
// Two-requester arbiter in front of a single-port LUTRAM.
// LUTRAM_ACCESS_ARBITER_INIT_SWEEP_EN adds a zeroing sweep after reset.
module lutram_access_arbiter
  import lutram_access_arbiter_pkg::*;
#(
  parameter int unsigned SINGLE_ELEMENT_SIZE_IN_BITS = 64,
  parameter int unsigned NUMBER_SETS                 = 64,
  parameter int unsigned SET_PTR_WIDTH_IN_BITS       = $clog2(NUMBER_SETS)
) (
  input  logic                                   clk_in,
  input  logic                                   reset_n_in,

  input  logic                                   req0_valid_in,
  output logic                                   req0_ready_out,
  input  logic                                   req0_write_en_in,
  input  logic [SET_PTR_WIDTH_IN_BITS-1:0]       req0_addr_in,
  input  logic [SINGLE_ELEMENT_SIZE_IN_BITS-1:0] req0_data_in,
  output logic                                   resp0_valid_out,
  output logic [SINGLE_ELEMENT_SIZE_IN_BITS-1:0] resp0_data_out,

  input  logic                                   req1_valid_in,
  output logic                                   req1_ready_out,
  input  logic                                   req1_write_en_in,
  input  logic [SET_PTR_WIDTH_IN_BITS-1:0]       req1_addr_in,
  input  logic [SINGLE_ELEMENT_SIZE_IN_BITS-1:0] req1_data_in,
  output logic                                   resp1_valid_out,
  output logic [SINGLE_ELEMENT_SIZE_IN_BITS-1:0] resp1_data_out,

  output logic                                   lutram_access_en_out,
  output logic                                   lutram_write_en_out,
  output logic [SET_PTR_WIDTH_IN_BITS-1:0]       lutram_addr_out,
  output logic [SINGLE_ELEMENT_SIZE_IN_BITS-1:0] lutram_write_data_out,
  input  logic [SINGLE_ELEMENT_SIZE_IN_BITS-1:0] lutram_read_data_in,

  output logic                                   init_done_out
);

  localparam int unsigned AW = SET_PTR_WIDTH_IN_BITS;
  localparam int unsigned DW = SINGLE_ELEMENT_SIZE_IN_BITS;

  logic               sweeping;
  logic               serving;
  logic               done_d;
  logic               done_q;
  logic [AW-1:0]      sweep_addr;
  logic [NUM_REQ-1:0] gnt;
  logic               rd0;
  logic               rd1;
  logic               resp0_valid_q;
  logic               resp1_valid_q;
  logic [DW-1:0]      resp0_data_q;
  logic [DW-1:0]      resp1_data_q;

`ifdef LUTRAM_ACCESS_ARBITER_INIT_SWEEP_EN
  localparam logic [AW-1:0] LAST_SET = AW'(NUMBER_SETS - 1);

  state_e        state_q;
  state_e        state_d;
  logic [AW-1:0] sweep_q;
  logic [AW-1:0] sweep_d;

  always_ff @(posedge clk_in or negedge reset_n_in) begin
    if (!reset_n_in) begin
      state_q <= INIT_SWEEP;
      sweep_q <= '0;
    end else begin
      state_q <= state_d;
      sweep_q <= sweep_d;
    end
  end

  // The counter parks on the last set instead of wrapping
  always_comb begin
    state_d = state_q;
    sweep_d = sweep_q;
    case (state_q)
      INIT_SWEEP: begin
        if (sweep_q == LAST_SET) state_d = SERVE;
        else                     sweep_d = sweep_q + 1'b1;
      end
      SERVE:   ;
      default: state_d = INIT_SWEEP;
    endcase
  end

  assign sweeping   = (state_q == INIT_SWEEP);
  assign serving    = (state_q == SERVE);
  assign sweep_addr = sweep_q;
  assign done_d     = (state_d == SERVE);
`else
  assign sweeping   = 1'b0;
  assign serving    = 1'b1;
  assign sweep_addr = '0;
  assign done_d     = 1'b1;
`endif

  rr_arbiter_2 u_rr (
    .clk_in     (clk_in),
    .reset_n_in (reset_n_in),
    .en_in      (serving & reset_n_in),
    .req_in     ({req1_valid_in, req0_valid_in}),
    .grant_out  (gnt)
  );

  assign req0_ready_out = gnt[REQ0];
  assign req1_ready_out = gnt[REQ1];

  always_comb begin
    lutram_access_en_out  = 1'b0;
    lutram_write_en_out   = 1'b0;
    lutram_addr_out       = '0;
    lutram_write_data_out = '0;
    unique case (1'b1)
      (sweeping & reset_n_in): begin
        lutram_access_en_out = 1'b1;
        lutram_write_en_out  = 1'b1;
        lutram_addr_out      = sweep_addr;
      end
      gnt[REQ0]: begin
        lutram_access_en_out  = 1'b1;
        lutram_write_en_out   = req0_write_en_in;
        lutram_addr_out       = req0_addr_in;
        lutram_write_data_out = req0_data_in;
      end
      gnt[REQ1]: begin
        lutram_access_en_out  = 1'b1;
        lutram_write_en_out   = req1_write_en_in;
        lutram_addr_out       = req1_addr_in;
        lutram_write_data_out = req1_data_in;
      end
      default: ;
    endcase
  end

  assign rd0 = gnt[REQ0] & ~req0_write_en_in;
  assign rd1 = gnt[REQ1] & ~req1_write_en_in;

  always_ff @(posedge clk_in or negedge reset_n_in) begin
    if (!reset_n_in) begin
      resp0_valid_q <= 1'b0;
      resp1_valid_q <= 1'b0;
      resp0_data_q  <= '0;
      resp1_data_q  <= '0;
      done_q        <= 1'b0;
    end else begin
      resp0_valid_q <= rd0;
      resp1_valid_q <= rd1;
      if (rd0) resp0_data_q <= lutram_read_data_in;
      if (rd1) resp1_data_q <= lutram_read_data_in;
      done_q <= done_d;
    end
  end

  assign resp0_valid_out = resp0_valid_q;
  assign resp1_valid_out = resp1_valid_q;
  assign resp0_data_out  = resp0_data_q;
  assign resp1_data_out  = resp1_data_q;
  assign init_done_out   = done_q;

endmodule

// File: tb/tb_lutram_access_arbiter.sv
// Directed bench for lutram_access_arbiter with a reference model.
// Works with or without LUTRAM_ACCESS_ARBITER_INIT_SWEEP_EN.
module tb_lutram_access_arbiter;

  localparam int DW = 64;
  localparam int N  = 64;
  localparam int AW = 6;
`ifdef LUTRAM_ACCESS_ARBITER_INIT_SWEEP_EN
  localparam int SWEEP_CYC = N;
  localparam int DONE_CYC  = N;
  localparam int DONE_LIT  = 65;
`else
  localparam int SWEEP_CYC = 0;
  localparam int DONE_CYC  = 1;
  localparam int DONE_LIT  = 2;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  lutram_access_arbiter_if #(
    .SINGLE_ELEMENT_SIZE_IN_BITS(DW),
    .SET_PTR_WIDTH_IN_BITS(AW)
  ) rq0 (), rq1 ();

  logic          l_en, l_we, done;
  logic [AW-1:0] l_addr;
  logic [DW-1:0] l_wd, l_rd;
  logic [DW-1:0] ram [N];

  lutram_access_arbiter #(
    .SINGLE_ELEMENT_SIZE_IN_BITS(DW),
    .NUMBER_SETS(N),
    .SET_PTR_WIDTH_IN_BITS(AW)
  ) dut (
    .clk_in                (clk),
    .reset_n_in            (rst_n),
    .req0_valid_in         (rq0.valid),
    .req0_ready_out        (rq0.ready),
    .req0_write_en_in      (rq0.write_en),
    .req0_addr_in          (rq0.addr),
    .req0_data_in          (rq0.data),
    .resp0_valid_out       (rq0.resp_valid),
    .resp0_data_out        (rq0.resp_data),
    .req1_valid_in         (rq1.valid),
    .req1_ready_out        (rq1.ready),
    .req1_write_en_in      (rq1.write_en),
    .req1_addr_in          (rq1.addr),
    .req1_data_in          (rq1.data),
    .resp1_valid_out       (rq1.resp_valid),
    .resp1_data_out        (rq1.resp_data),
    .lutram_access_en_out  (l_en),
    .lutram_write_en_out   (l_we),
    .lutram_addr_out       (l_addr),
    .lutram_write_data_out (l_wd),
    .lutram_read_data_in   (l_rd),
    .init_done_out         (done)
  );

  // Single-port LUTRAM: synchronous write, combinational read
  assign l_rd = ram[l_addr];
  always @(posedge clk) if (l_en && l_we) ram[l_addr] <= l_wd;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [DW-1:0] act,
                     input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Reference model state
  logic [DW-1:0] m_mem [N];
  int            m_cyc = 0;
  int            m_pref = 0;
  bit            m_rv [2];
  logic [DW-1:0] m_rd [2];
  int            glog [$];

  always @(negedge clk) begin : compare
    logic          vv [2];
    logic          ww [2];
    logic [AW-1:0] aa [2];
    logic [DW-1:0] dd [2];
    int            g;
    bit            sw;
    if (!rst_n) begin
      chk("rst_ready0", 64'(rq0.ready), 64'(0));
      chk("rst_ready1", 64'(rq1.ready), 64'(0));
      chk("rst_rv0", 64'(rq0.resp_valid), 64'(0));
      chk("rst_rv1", 64'(rq1.resp_valid), 64'(0));
      chk("rst_rd0", rq0.resp_data, 64'(0));
      chk("rst_rd1", rq1.resp_data, 64'(0));
      chk("rst_en", 64'(l_en), 64'(0));
      chk("rst_we", 64'(l_we), 64'(0));
      chk("rst_done", 64'(done), 64'(0));
      m_cyc = 0;
      m_pref = 0;
      m_rv[0] = 0; m_rv[1] = 0;
      m_rd[0] = '0; m_rd[1] = '0;
    end else begin
      vv[0] = rq0.valid;    vv[1] = rq1.valid;
      ww[0] = rq0.write_en; ww[1] = rq1.write_en;
      aa[0] = rq0.addr;     aa[1] = rq1.addr;
      dd[0] = rq0.data;     dd[1] = rq1.data;
      sw = (m_cyc < SWEEP_CYC);
      g = -1;
      if (!sw) begin
        if (vv[0] && vv[1]) g = m_pref;
        else if (vv[0])     g = 0;
        else if (vv[1])     g = 1;
      end
      chk("ready0", 64'(rq0.ready), 64'(g == 0));
      chk("ready1", 64'(rq1.ready), 64'(g == 1));
      chk("init_done", 64'(done), 64'(m_cyc >= DONE_CYC));
      chk("resp_valid0", 64'(rq0.resp_valid), 64'(m_rv[0]));
      chk("resp_valid1", 64'(rq1.resp_valid), 64'(m_rv[1]));
      chk("resp_data0", rq0.resp_data, m_rd[0]);
      chk("resp_data1", rq1.resp_data, m_rd[1]);
      if (sw) begin
        chk("sweep_en", 64'(l_en), 64'(1));
        chk("sweep_we", 64'(l_we), 64'(1));
        chk("sweep_addr", 64'(l_addr), 64'(m_cyc));
        chk("sweep_data", l_wd, 64'(0));
      end else if (g >= 0) begin
        chk("lut_en", 64'(l_en), 64'(1));
        chk("lut_we", 64'(l_we), 64'(ww[g]));
        chk("lut_addr", 64'(l_addr), 64'(aa[g]));
        chk("lut_wdata", l_wd, dd[g]);
      end else begin
        chk("idle_en", 64'(l_en), 64'(0));
        chk("idle_we", 64'(l_we), 64'(0));
      end
      if (rq0.ready) glog.push_back(0);
      if (rq1.ready) glog.push_back(1);
      m_rv[0] = 0; m_rv[1] = 0;
      if (sw) begin
        m_mem[m_cyc] = '0;
      end else if (g >= 0) begin
        if (ww[g]) begin
          m_mem[aa[g]] = dd[g];
        end else begin
          m_rv[g] = 1;
          m_rd[g] = m_mem[aa[g]];
        end
        m_pref = (g == 0) ? 1 : 0;
      end
      if (m_cyc < 100000) m_cyc++;
    end
  end

  task automatic set_req(input int i, input bit v, input bit we,
                         input int a, input logic [DW-1:0] d);
    if (i == 0) begin
      rq0.valid = v; rq0.write_en = we; rq0.addr = AW'(a); rq0.data = d;
    end else begin
      rq1.valid = v; rq1.write_en = we; rq1.addr = AW'(a); rq1.data = d;
    end
  endtask

  task automatic wait_done(output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!done && n < 200);
  endtask

  initial begin : main
    int  n;
    bit  p0, p1, g0, g1;
    for (int i = 0; i < N; i++) begin
      ram[i]   = DW'(i * 3 + 1);
      m_mem[i] = DW'(i * 3 + 1);
    end
    set_req(0, 0, 0, 0, '0);
    set_req(1, 0, 0, 0, '0);
    repeat (3) @(posedge clk);

    // Both requesters reading continuously straight out of reset
    @(posedge clk); #1;
    rst_n = 1'b1;
    set_req(0, 1, 0, 5, '0);
    set_req(1, 1, 0, 7, '0);
    wait_done(n);
    chk("init_done_cycle", 64'(n), 64'(DONE_LIT));
    n = 0;
    while (glog.size() < 4 && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("grant_count", 64'(glog.size() >= 4), 64'(1));
    if (glog.size() >= 4) begin
      chk("grant_seq0", 64'(glog[0]), 64'(0));
      chk("grant_seq1", 64'(glog[1]), 64'(1));
      chk("grant_seq2", 64'(glog[2]), 64'(0));
      chk("grant_seq3", 64'(glog[3]), 64'(1));
    end
    @(posedge clk); #1;
    set_req(0, 0, 0, 0, '0);
    set_req(1, 0, 0, 0, '0);
    @(negedge clk);
`ifdef LUTRAM_ACCESS_ARBITER_INIT_SWEEP_EN
    chk("read5_zero", rq0.resp_data, 64'(0));
    chk("read7_zero", rq1.resp_data, 64'(0));
`else
    chk("read5_init", rq0.resp_data, 64'(16));
    chk("read7_init", rq1.resp_data, 64'(22));
`endif

    // req0 writes, req1 reads the same address one cycle later
    @(posedge clk); #1;
    set_req(0, 1, 1, 3, 64'hDEAD);
    @(negedge clk);
    chk("wr_grant0", 64'(rq0.ready), 64'(1));
    @(posedge clk); #1;
    set_req(0, 0, 0, 0, '0);
    set_req(1, 1, 0, 3, '0);
    @(negedge clk);
    chk("rd_grant1", 64'(rq1.ready), 64'(1));
    chk("rd_rv1_early", 64'(rq1.resp_valid), 64'(0));
    @(posedge clk); #1;
    set_req(1, 0, 0, 0, '0);
    @(negedge clk);
    chk("raw_rv1", 64'(rq1.resp_valid), 64'(1));
    chk("raw_data1", rq1.resp_data, 64'hDEAD);
    chk("raw_rv0", 64'(rq0.resp_valid), 64'(0));

    // Read-after-write on the top address
    @(posedge clk); #1;
    set_req(0, 1, 1, 63, 64'h1);
    @(posedge clk); #1;
    set_req(0, 1, 0, 63, '0);
    @(posedge clk); #1;
    set_req(0, 0, 0, 0, '0);
    @(negedge clk);
    chk("raw63_rv0", 64'(rq0.resp_valid), 64'(1));
    chk("raw63_data0", rq0.resp_data, 64'h1);

    // Contending write and read on one address, each held until granted
    @(posedge clk); #1;
    set_req(0, 1, 1, 10, 64'hBEEF);
    set_req(1, 1, 0, 10, '0);
    p0 = 1; p1 = 1;
    for (int k = 0; k < 4 && (p0 || p1); k++) begin
      @(negedge clk);
      g0 = rq0.ready; g1 = rq1.ready;
      @(posedge clk); #1;
      if (g0) begin set_req(0, 0, 0, 0, '0); p0 = 0; end
      if (g1) begin set_req(1, 0, 0, 0, '0); p1 = 0; end
    end
    chk("no_starve", 64'(p0 | p1), 64'(0));
    repeat (2) @(negedge clk);

    // Reset during a pending read response
    @(posedge clk); #1;
    set_req(1, 1, 0, 10, '0);
    @(posedge clk); #1;
    set_req(1, 0, 0, 0, '0);
    chk("pend_rv1", 64'(rq1.resp_valid), 64'(1));
    rst_n = 1'b0;
    #1;
    chk("abort_rv1", 64'(rq1.resp_valid), 64'(0));
    chk("abort_rd1", rq1.resp_data, 64'(0));
    chk("abort_done", 64'(done), 64'(0));
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

`ifdef LUTRAM_ACCESS_ARBITER_INIT_SWEEP_EN
    // Reset again in the middle of the sweep
    repeat (20) @(posedge clk);
    @(negedge clk);
    chk("sweep_at20", 64'(l_addr), 64'(20));
    #1 rst_n = 1'b0;
    #1;
    chk("mid_rst_en", 64'(l_en), 64'(0));
    chk("mid_rst_done", 64'(done), 64'(0));
    @(posedge clk); #1;
    rst_n = 1'b1;
    #1;
    chk("restart_addr", 64'(l_addr), 64'(0));
`endif
    wait_done(n);
    chk("reinit_cycle", 64'(n), 64'(DONE_LIT));
    repeat (2) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
